// File: rtl/mem_access_master.sv
// ============================================================================
// Module   : mem_access_master
// Brief    : CPU load/store to Wishbone (pipelined) single-access master with
//            byte/half/word lanes, alignment check and optional ack timeout
//            (enabled by defining MEM_ACCESS_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_STROBE = 2'd1;
    localparam logic [1:0] c_S_WAIT   = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic        r_we;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_lsb;
    logic        r_unsigned;
    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic [3:0]  r_wb_sel;
    logic [31:0] r_rdata;

    logic        w_bus;
    logic        w_misaligned;
    logic        w_ack_now;
    logic        w_tmo;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    assign w_bus = (r_state == c_S_STROBE) || (r_state == c_S_WAIT);

    // Size 11 behaves as a word everywhere, hence the use of i_size[1] alone.
    assign w_misaligned = ((i_size == 2'b01) && i_addr[0]) ||
                          (i_size[1] && (i_addr[1:0] != 2'b00));

    // A stalled strobe has not been accepted, so an ack alongside it is ignored.
    assign w_ack_now = i_wb_ack &&
                       ((r_state == c_S_WAIT) ||
                        ((r_state == c_S_STROBE) && !i_wb_stall));

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = i_wdata;
        case (i_size)
            2'b00: begin
                w_sel   = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_sel   = 4'b0011 << i_addr[1:0];
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    assign w_shifted = i_wb_data >> {r_lsb, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'h0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = r_unsigned ? {16'h0, w_shifted[15:0]}
                                         : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [c_CNT_W-1:0] r_cnt;

    // Counter sits at zero in IDLE, so it starts from zero on entering STROBE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_bus) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_tmo = w_bus && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout feature the limit is unused; keep it visible.
    if (TIMEOUT_CYCLES > 0) begin : g_no_tmo
        assign w_tmo = 1'b0;
    end else begin : g_no_tmo_zero
        assign w_tmo = 1'b0;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_S_IDLE;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'b00;
            r_lsb      <= 2'b00;
            r_unsigned <= 1'b0;
            r_wb_addr  <= 32'h0;
            r_wb_data  <= 32'h0;
            r_wb_sel   <= 4'b0000;
            r_rdata    <= 32'h0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_err <= 1'b0;
                    if (i_req) begin
                        r_we       <= i_we;
                        r_size     <= i_size;
                        r_lsb      <= i_addr[1:0];
                        r_unsigned <= i_unsigned;
                        r_wb_addr  <= {i_addr[31:2], 2'b00};
                        r_wb_data  <= w_wdata;
                        r_wb_sel   <= w_sel;
                        if (w_misaligned) begin
                            r_state <= c_S_DONE;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= c_S_STROBE;
                        end
                    end
                end
                c_S_STROBE, c_S_WAIT: begin
                    if (w_ack_now) begin
                        r_state <= c_S_DONE;
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                    end else if (w_tmo) begin
                        r_state <= c_S_DONE;
                        r_err   <= 1'b1;
                    end else if ((r_state == c_S_STROBE) && !i_wb_stall) begin
                        r_state <= c_S_WAIT;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = (r_state != c_S_IDLE);
    assign o_done    = (r_state == c_S_DONE);
    assign o_err     = r_err && (r_state == c_S_DONE);
    assign o_rdata   = r_rdata;
    assign o_wb_cyc  = w_bus;
    assign o_wb_stb  = (r_state == c_S_STROBE);
    assign o_wb_we   = r_we && w_bus;
    assign o_wb_addr = r_wb_addr;
    assign o_wb_data = r_wb_data;
    assign o_wb_sel  = r_wb_sel;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_master.sv
// ============================================================================
// Module   : tb_mem_access_master
// Brief    : Directed self-checking bench for mem_access_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_stall;
    logic [31:0] wb_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_master #(.TIMEOUT_CYCLES(8)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_we       (we),
        .i_size     (size),
        .i_unsigned (uns),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_rdata    (rdata),
        .o_wb_cyc   (wb_cyc),
        .o_wb_stb   (wb_stb),
        .o_wb_we    (wb_we),
        .o_wb_addr  (wb_addr),
        .o_wb_data  (wb_data),
        .o_wb_sel   (wb_sel),
        .i_wb_ack   (wb_ack),
        .i_wb_stall (wb_stall),
        .i_wb_data  (wb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        size  = s;
        uns   = u;
        addr  = a;
        wdata = d;
    endtask

    // Load with ack one cycle after the strobe; expects rdata on the done cycle.
    task automatic do_load(input string tag, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] slave,
                           input logic [3:0] exp_sel, input logic [31:0] exp_rd);
        issue(1'b0, s, u, a, 32'h0);
        tick();
        req = 1'b0;
        chk({tag, "_sel"}, {28'h0, wb_sel}, {28'h0, exp_sel});
        chk({tag, "_we"}, {31'h0, wb_we}, 32'h0);
        tick();
        wb_ack   = 1'b1;
        wb_rdata = slave;
        tick();
        wb_ack   = 1'b0;
        wb_rdata = 32'h0;
        chk({tag, "_done"}, {30'h0, done, err}, 32'h2);
        chk({tag, "_rdata"}, rdata, exp_rd);
        tick();
        chk({tag, "_hold"}, {31'h0, done}, 32'h0);
        chk({tag, "_rdata_hold"}, rdata, exp_rd);
    endtask

    initial begin
        int stb_cnt;
        int done_cnt;

        rst      = 1'b1;
        req      = 1'b0;
        we       = 1'b0;
        size     = 2'b00;
        uns      = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        wb_ack   = 1'b0;
        wb_stall = 1'b0;
        wb_rdata = 32'h0;

        tick();
        tick();
        chk("rst_ctrl", {26'h0, busy, done, err, wb_cyc, wb_stb, wb_we}, 32'h0);
        chk("rst_sel", {28'h0, wb_sel}, 32'h0);
        chk("rst_addr", wb_addr, 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        // Word store issued right as reset releases
        rst = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        tick();
        req = 1'b0;
        chk("ws_ctrl", {29'h0, wb_cyc, wb_stb, wb_we}, 32'h7);
        chk("ws_addr", wb_addr, 32'h10);
        chk("ws_sel", {28'h0, wb_sel}, 32'hF);
        chk("ws_data", wb_data, 32'hDEADBEEF);
        tick();
        chk("ws_wait", {30'h0, wb_cyc, wb_stb}, 32'h2);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("ws_done", {29'h0, done, err, wb_cyc}, 32'h4);
        tick();
        chk("ws_idle", {30'h0, busy, done}, 32'h0);

        do_load("lb_s", 2'b00, 1'b0, 32'h13, 32'h80FFFFFF, 4'b1000, 32'hFFFFFF80);
        do_load("lb_u", 2'b00, 1'b1, 32'h13, 32'h80FFFFFF, 4'b1000, 32'h00000080);

        // Half load with ack in the same cycle as an unstalled strobe
        issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        tick();
        req      = 1'b0;
        wb_ack   = 1'b1;
        wb_rdata = 32'h80011234;
        tick();
        wb_ack   = 1'b0;
        chk("lh_fast_done", {30'h0, done, err}, 32'h2);
        chk("lh_fast_rdata", rdata, 32'hFFFF8001);
        tick();

        // Half store with the slave stalling three cycles
        issue(1'b1, 2'b01, 1'b0, 32'h2, 32'h1234ABCD);
        tick();
        req      = 1'b0;
        stb_cnt  = 0;
        done_cnt = 0;
        chk("hs_sel", {28'h0, wb_sel}, 32'hC);
        chk("hs_data", wb_data, 32'hABCDABCD);
        for (int i = 1; i <= 10; i++) begin
            if (wb_stb) stb_cnt++;
            if (done) done_cnt++;
            wb_stall = (i <= 3);
            wb_ack   = (i == 5);
            if (i < 10) tick();
        end
        wb_stall = 1'b0;
        wb_ack   = 1'b0;
        chk("hs_stb_cycles", stb_cnt, 4);
        chk("hs_done_pulses", done_cnt, 1);
        tick();

        // Misaligned word load: immediate error, no bus cycle
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        tick();
        req = 1'b0;
        chk("mis_flags", {28'h0, busy, done, err, wb_cyc}, 32'hE);
        chk("mis_rdata", rdata, 32'hFFFF8001);
        tick();
        chk("mis_idle", {30'h0, busy, done}, 32'h0);

        // Reset during WAIT_ACK, then a late ack
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        tick();
        req = 1'b0;
        tick();
        chk("rw_inwait", {30'h0, wb_cyc, wb_stb}, 32'h2);
        rst = 1'b1;
        #1;
        chk("rw_async", {29'h0, wb_cyc, wb_stb, busy}, 32'h0);
        tick();
        rst    = 1'b0;
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("rw_late_ack", {30'h0, done, busy}, 32'h0);
        tick();
        chk("rw_late_ack2", {30'h0, done, busy}, 32'h0);
        chk("rw_rdata_clr", rdata, 32'h0);

        // Load with no ack: timeout when enabled, indefinite wait otherwise
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        tick();
        req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("to_cyc%0d", i), {31'h0, wb_cyc}, 32'h1);
            tick();
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        chk("to_expire", {29'h0, wb_cyc, done, err}, 32'h3);
        tick();
        chk("to_idle", {31'h0, busy}, 32'h0);
`else
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("to_hold%0d", i), {30'h0, wb_cyc, done}, 32'h2);
            tick();
        end
        wb_ack   = 1'b1;
        wb_rdata = 32'h0BADF00D;
        tick();
        wb_ack   = 1'b0;
        chk("to_late_done", {30'h0, done, err}, 32'h2);
        chk("to_late_rdata", rdata, 32'h0BADF00D);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
